ctrl_sequencer: RTL and testbench

Hard-wired control unit for the single-bus Mini-SRC datapath. It steps through a fetch/decode/execute state machine and drives every register-enable, bus-driver, ALU-select and memory strobe the datapath consumes. The register-select one-hots are decoded from the IR fields. It sits beside the datapath and replaces the testbench-driven control signals used in Phase 1.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_decode.sv | 62 ++++++
 rtl/ctrl_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the Mini-SRC hard-wired control unit.
// States, instruction classes, opcodes, ALU codes, IR fields.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_WAIT,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ITYPE,
    C_LD,
    C_ST,
    C_MULDIV,
    C_NOP,
    C_HALT,
    C_ILL
  } iclass_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  function automatic logic [15:0] onehot16(
    input logic [3:0] r
  );
    return 16'h0001 << r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction class and ALU code.
// CTRL_MULDIV_EN enables the mul/div class.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output logic [2:0] cls_o,
  output logic [4:0] alu_o
);

  logic is_r;
  logic is_md;

  assign is_r = (op_i >= OP_ADD) &&
                (op_i <= OP_ROL);

`ifdef CTRL_MULDIV_EN
  assign is_md = (op_i == OP_MUL) ||
                 (op_i == OP_DIV);
`else
  assign is_md = 1'b0;
`endif

  always_comb begin
    cls_o = C_ILL;
    alu_o = '0;
    unique case (1'b1)
      is_r: begin
        cls_o = C_RTYPE;
        alu_o = op_i;
      end
      op_i == OP_ADDI: begin
        cls_o = C_ITYPE;
        alu_o = ALU_ADD;
      end
      op_i == OP_ANDI: begin
        cls_o = C_ITYPE;
        alu_o = ALU_AND;
      end
      op_i == OP_ORI: begin
        cls_o = C_ITYPE;
        alu_o = ALU_OR;
      end
      is_md: begin
        cls_o = C_MULDIV;
        alu_o = op_i;
      end
      op_i == OP_LD: begin
        cls_o = C_LD;
        alu_o = ALU_ADD;
      end
      op_i == OP_ST: begin
        cls_o = C_ST;
        alu_o = ALU_ADD;
      end
      op_i == OP_NOP:  cls_o = C_NOP;
      op_i == OP_HALT: cls_o = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for the Mini-SRC datapath.
// Optional mul/div sequences under CTRL_MULDIV_EN.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [15:0]      reg_in,
  output logic [15:0]      reg_out,
  output logic             pc_out,
  output logic             zlow_out,
  output logic             zhigh_out,
  output logic             mdr_out,
  output logic             hi_out,
  output logic             lo_out,
  output logic             c_out,
  output logic             pc_in,
  output logic             ir_in,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             y_in,
  output logic             z_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic             inc_pc,
  output logic             read,
  output logic             write,
  output logic [4:0]       alu_ctrl,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done;
  logic [2:0]       cls_w;
  iclass_e          cls;
  logic [4:0]       alu;
  logic [15:0]      oh_ra, oh_rb, oh_rc;
  logic             unused_ir;

  ctrl_decode u_dec (
    .op_i  (ir[OP_HI:OP_LO]),
    .cls_o (cls_w),
    .alu_o (alu)
  );

  assign cls   = iclass_e'(cls_w);
  assign oh_ra = onehot16(ir[RA_HI:RA_LO]);
  assign oh_rb = onehot16(ir[RB_HI:RB_LO]);
  assign oh_rc = onehot16(ir[RC_HI:RC_LO]);
  assign unused_ir = ^ir[RC_LO-1:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
  assign retired_d = done ? retired_q + CNT_W'(1)
                          : retired_q;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2: begin
        unique case (cls)
          C_HALT:       state_d = S_HALT;
          C_NOP, C_ILL: done = 1'b1;
          default:      state_d = S_T3;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (cls == C_RTYPE || cls == C_ITYPE)
          done = 1'b1;
        else
          state_d = S_T6;
      end
      S_T6: begin
        unique case (cls)
          C_LD:    if (mem_ready) state_d = S_T7;
          C_ST:    state_d = S_T7;
          default: done = 1'b1;
        endcase
      end
      S_T7: begin
        if (cls == C_LD || mem_ready)
          done = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // run is only looked at when an instruction retires
    if (done) state_d = run ? S_T0 : S_IDLE;
  end

  always_comb begin
    reg_in    = '0;
    reg_out   = '0;
    pc_out    = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    mdr_out   = 1'b0;
    hi_out    = 1'b0;
    lo_out    = 1'b0;
    c_out     = 1'b0;
    pc_in     = 1'b0;
    ir_in     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    inc_pc    = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    alu_ctrl  = '0;
    illegal   = 1'b0;
    busy      = (state_q != S_IDLE) &&
                (state_q != S_HALT);
    halted    = (state_q == S_HALT);
    unique case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        illegal = (cls == C_ILL);
      end
      S_T3: begin
        y_in    = 1'b1;
        reg_out = (cls == C_MULDIV) ? oh_ra
                                    : oh_rb;
      end
      S_T4: begin
        z_in     = 1'b1;
        alu_ctrl = alu;
        unique case (cls)
          C_RTYPE:  reg_out = oh_rc;
          C_MULDIV: reg_out = oh_rb;
          default:  c_out = 1'b1;
        endcase
      end
      S_T5: begin
        zlow_out = 1'b1;
        unique case (cls)
          C_RTYPE, C_ITYPE: reg_in = oh_ra;
`ifdef CTRL_MULDIV_EN
          C_MULDIV:         lo_in = 1'b1;
`endif
          default:          mar_in = 1'b1;
        endcase
      end
      S_T6: begin
        unique case (cls)
          C_LD: begin
            read   = 1'b1;
            mdr_in = 1'b1;
          end
          C_ST: begin
            reg_out = oh_ra;
            mdr_in  = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: begin
            zhigh_out = 1'b1;
            hi_in     = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        if (cls == C_LD) begin
          mdr_out = 1'b1;
          reg_in  = oh_ra;
        end else begin
          write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer.
// Expected per-cycle controls are queued, then replayed.
module tb_ctrl_sequencer;

  localparam int CW = 4;
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear, run, mem_ready;
  logic [31:0]   ir;
  logic [15:0]   reg_in, reg_out;
  logic          pc_out, zlow_out, zhigh_out;
  logic          mdr_out, hi_out, lo_out, c_out;
  logic          pc_in, ir_in, mar_in, mdr_in;
  logic          y_in, z_in, hi_in, lo_in;
  logic          inc_pc, read, write;
  logic [4:0]    alu_ctrl;
  logic          busy, halted, illegal;
  logic [CW-1:0] retired;

  ctrl_sequencer #(.CNT_W(CW)) dut (
    .clock     (clock),
    .clear     (clear),
    .run       (run),
    .ir        (ir),
    .mem_ready (mem_ready),
    .reg_in    (reg_in),
    .reg_out   (reg_out),
    .pc_out    (pc_out),
    .zlow_out  (zlow_out),
    .zhigh_out (zhigh_out),
    .mdr_out   (mdr_out),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .c_out     (c_out),
    .pc_in     (pc_in),
    .ir_in     (ir_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .inc_pc    (inc_pc),
    .read      (read),
    .write     (write),
    .alu_ctrl  (alu_ctrl),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pco, zlo, zho, mdro, hio, loo, co;
    logic pci, iri, mari, mdri, yi, zi, hii, loi;
    logic incpc, rd, wr;
    logic [4:0] alu;
    logic bsy, hlt, ill;
  } ov_t;

  typedef struct {
    ov_t           e;
    logic          clr;
    logic          rn;
    logic          mr;
    logic [31:0]   iv;
    logic [CW-1:0] ret;
    string         tag;
  } item_t;

  ov_t   obs;
  assign obs = {reg_in, reg_out,
    pc_out, zlow_out, zhigh_out, mdr_out,
    hi_out, lo_out, c_out,
    pc_in, ir_in, mar_in, mdr_in,
    y_in, z_in, hi_in, lo_in,
    inc_pc, read, write, alu_ctrl,
    busy, halted, illegal};

  item_t         q[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_ret = '0;
  logic [31:0]   cur_ir = '0;
  string         cur_tag = "init";
  int            step_n, cut_at;
  bit            aborted;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] oh(
    input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic logic [31:0] mk(
    input logic [4:0] op, input logic [3:0] ra,
    input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  // 0 R, 1 I, 2 ld, 3 st, 4 mul/div, 5 nop, 6 halt, 7 ill
  function automatic int kind(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 0;
    if (op inside {5'd12, 5'd13, 5'd14}) return 1;
    if (op == 5'd0) return 2;
    if (op == 5'd2) return 3;
    if (op == 5'd15 || op == 5'd16)
      return MD ? 4 : 7;
    if (op == 5'd26) return 5;
    if (op == 5'd27) return 6;
    return 7;
  endfunction

  function automatic ov_t act();
    ov_t e = '0;
    e.bsy = 1'b1;
    return e;
  endfunction

  task automatic push_raw(input ov_t e,
      input logic clr, input logic rn,
      input logic mr, input bit done);
    item_t it;
    if (clr) exp_ret = '0;
    else if (done) exp_ret = exp_ret + CW'(1);
    it.e = e;
    it.clr = clr;
    it.rn = rn;
    it.mr = mr;
    it.iv = cur_ir;
    it.ret = exp_ret;
    it.tag = $sformatf("%s_c%0d", cur_tag, q.size());
    q.push_back(it);
  endtask

  task automatic push_step(input ov_t e,
      input logic rn, input logic mr, input bit done);
    if (aborted) return;
    if (step_n == cut_at) begin
      push_raw('0, 1'b1, 1'b0, 1'b1, 1'b0);
      aborted = 1'b1;
      return;
    end
    step_n++;
    push_raw(e, 1'b0, rn, mr, done);
  endtask

  task automatic do_instr(input logic [31:0] iv,
      input string tag, input bit fromidle,
      input int w1, input int w6,
      input logic rmid, input logic rend,
      input int cut);
    ov_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int k;
    cur_ir = iv;
    cur_tag = tag;
    step_n = 0;
    cut_at = cut;
    aborted = 1'b0;
    op = iv[31:27];
    ra = iv[26:23];
    rb = iv[22:19];
    rc = iv[18:15];
    k = kind(op);
    if (fromidle) push_step('0, 1'b1, 1'b1, 1'b0);
    e = act();
    e.pco = 1; e.mari = 1; e.incpc = 1; e.zi = 1;
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    e.zlo = 1; e.pci = 1; e.rd = 1; e.mdri = 1;
    repeat (w1) push_step(e, rmid, 1'b0, 1'b0);
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    e.mdro = 1; e.iri = 1;
    e.ill = (k == 7);
    if (k == 5 || k == 7) begin
      push_step(e, rend, 1'b1, 1'b1);
      return;
    end
    if (k == 6) begin
      push_step(e, rmid, 1'b1, 1'b0);
      return;
    end
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    e.yi = 1;
    e.rout = (k == 4) ? oh(ra) : oh(rb);
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    e.zi = 1;
    if (k == 0 || k == 4) e.alu = op;
    else if (k == 1)
      e.alu = (op == 5'd12) ? 5'd3 :
              (op == 5'd13) ? 5'd5 : 5'd6;
    else e.alu = 5'd3;
    if (k == 0) e.rout = oh(rc);
    else if (k == 4) e.rout = oh(rb);
    else e.co = 1;
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    e.zlo = 1;
    if (k <= 1) begin
      e.rin = oh(ra);
      push_step(e, rend, 1'b1, 1'b1);
      return;
    end
    if (k == 4) e.loi = 1;
    else e.mari = 1;
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    if (k == 4) begin
      e.zho = 1; e.hii = 1;
      push_step(e, rend, 1'b1, 1'b1);
      return;
    end
    if (k == 2) begin
      e.rd = 1; e.mdri = 1;
      repeat (w6) push_step(e, rmid, 1'b0, 1'b0);
    end else begin
      e.rout = oh(ra); e.mdri = 1;
    end
    push_step(e, rmid, 1'b1, 1'b0);
    e = act();
    if (k == 2) begin
      e.mdro = 1; e.rin = oh(ra);
    end else begin
      e.wr = 1;
      repeat (w6) push_step(e, rmid, 1'b0, 1'b0);
    end
    push_step(e, rend, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n, input logic rn);
    repeat (n) push_raw('0, 1'b0, rn, 1'b1, 1'b0);
  endtask

  task automatic reset_items(input string tag);
    cur_tag = tag;
    push_raw('0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_raw('0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    item_t it;
    ov_t   h;
    logic [4:0] rops [5];
    clear = 1'b1;
    run = 1'b0;
    mem_ready = 1'b1;
    ir = '0;
    rops[0] = 5'd4;
    rops[1] = 5'd5;
    rops[2] = 5'd9;
    rops[3] = 5'd11;
    rops[4] = 5'd7;

    reset_items("rst");
    cur_tag = "idle";
    idle(2, 1'b0);
    do_instr(mk(5'd3, 4'd3, 4'd1, 4'd2), "add",
             1, 0, 0, 1'b1, 1'b0, -1);
    idle(2, 1'b0);
    do_instr(mk(5'd0, 4'd4, 4'd5, 4'd0), "ld",
             1, 3, 2, 1'b0, 1'b1, -1);
    do_instr(mk(5'd12, 4'd5, 4'd6, 4'd0), "addi",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd2, 4'd7, 4'd8, 4'd0), "st",
             0, 1, 1, 1'b1, 1'b1, -1);
    do_instr(mk(5'd13, 4'd9, 4'd10, 4'd0), "andi",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd14, 4'd15, 4'd0, 4'd0), "ori",
             0, 0, 0, 1'b1, 1'b1, -1);
    foreach (rops[i])
      do_instr(mk(rops[i], 4'(i + 1), 4'(i + 6),
                  4'(15 - i)), $sformatf("r%0d", i),
               0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd15, 4'd0, 4'd1, 4'd2), "mul",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd16, 4'd3, 4'd4, 4'd0), "div",
             0, 1, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd31, 4'd0, 4'd0, 4'd0), "ill",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd1, 4'd0, 4'd0, 4'd0), "ill1",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd26, 4'd0, 4'd0, 4'd0), "nop",
             0, 0, 0, 1'b1, 1'b1, -1);
    do_instr(mk(5'd4, 4'd1, 4'd2, 4'd3), "subcut",
             0, 0, 0, 1'b1, 1'b1, 4);
    for (int i = 0; i < 16; i++)
      do_instr(mk(5'd26, 4'd0, 4'd0, 4'd0),
               $sformatf("nop%0d", i), (i == 0),
               0, 0, 1'b1, (i != 15), -1);
    idle(1, 1'b0);
    do_instr(mk(5'd27, 4'd0, 4'd0, 4'd0), "halt",
             1, 0, 0, 1'b1, 1'b1, -1);
    h = '0;
    h.hlt = 1'b1;
    repeat (20) push_raw(h, 1'b0, 1'b1, 1'b1, 1'b0);
    reset_items("unhalt");
    cur_tag = "post";
    idle(2, 1'b0);

    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clock);
      clear = ~it.clr;
      run = it.rn;
      mem_ready = it.mr;
      ir = it.iv;
      #1;
      check({it.tag, "_out"}, 64'(obs), 64'(it.e));
      @(posedge clock);
      #1;
      check({it.tag, "_ret"}, 64'(retired),
            64'(it.ret));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
